// File: rtl/adc_cal_pkg.sv
// adc_cal_pkg: shared sizes, constants and FSM state type for the ADC offset calibrator
package adc_cal_pkg;
  localparam int ADC_WAYS = 8;
  localparam int ADC_BITS = 9;
  localparam int TRIM_BITS = 8;
  localparam int AVG_LOG2 = 4;
  localparam int SETTLE_SAMPLES = 8;
  localparam int MIDSCALE = 256;
  localparam int ACC_BITS = ADC_BITS + AVG_LOG2;
  localparam int CNT_BITS = 6;
  localparam int WAY_BITS = $clog2(ADC_WAYS);
  localparam int BIT_BITS = $clog2(TRIM_BITS);
  localparam logic [TRIM_BITS-1:0] TRIM_RESET = 8'h80;
  localparam logic [ACC_BITS-1:0] ACC_THRESH = ACC_BITS'(MIDSCALE << AVG_LOG2);
  typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, DECIDE, NEXT_WAY, DONE} cal_state_t;
endpackage

// File: rtl/adc_offset_cal_if.sv
// adc_offset_cal_if: control, sample stream, manual trim port and trim outputs of the calibrator
interface adc_offset_cal_if;
  import adc_cal_pkg::*;
  logic start;
  logic busy;
  logic done;
  logic adc_valid;
  logic [ADC_WAYS*ADC_BITS-1:0] adc_data;
  logic cfg_wen;
  logic [WAY_BITS-1:0] cfg_way;
  logic [TRIM_BITS-1:0] cfg_trim;
  logic [ADC_WAYS*TRIM_BITS-1:0] osp;
  logic [ADC_WAYS*TRIM_BITS-1:0] osm;
  modport master(output start, adc_valid, adc_data, cfg_wen, cfg_way, cfg_trim, input busy, done, osp, osm);
  modport slave(input start, adc_valid, adc_data, cfg_wen, cfg_way, cfg_trim, output busy, done, osp, osm);
endinterface

// File: rtl/adc_cal_avg.sv
// adc_cal_avg: discards the first skip strobes after clear, then accumulates the next avg_n samples
module adc_cal_avg
  import adc_cal_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic valid,
  input  logic [ADC_BITS-1:0] data,
  input  logic [CNT_BITS-1:0] skip,
  input  logic [CNT_BITS-1:0] avg_n,
  output logic [ACC_BITS-1:0] acc,
  output logic skip_done,
  output logic acc_done
);
  logic [CNT_BITS-1:0] cnt, cnt_n;
  assign cnt_n = cnt + 1'b1;
  assign skip_done = valid && cnt_n == skip;
  assign acc_done = valid && cnt_n == skip + avg_n;
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (valid) begin
      cnt <= cnt_n;
      if (cnt >= skip) acc <= acc + ACC_BITS'(data);
    end
  end
endmodule

// File: rtl/adc_offset_cal.sv
// adc_offset_cal: per-way SAR search of comparator offset trims driven by averaged ADC output
module adc_offset_cal
  import adc_cal_pkg::*;
(
  input logic clock,
  input logic reset,
  adc_offset_cal_if.slave bus
);
  cal_state_t state, state_n;
  logic [WAY_BITS-1:0] way;
  logic [BIT_BITS-1:0] bit_idx;
  logic [TRIM_BITS-1:0] trim [ADC_WAYS];
  logic [ACC_BITS-1:0] acc;
  logic skip_done, acc_done, avg_clear, last_way;
  assign last_way = way == WAY_BITS'(ADC_WAYS - 1);
  assign avg_clear = state != SETTLE && state != ACCUM;
  adc_cal_avg u_avg (
    .clock(clock),
    .reset(reset),
    .clear(avg_clear),
    .valid(bus.adc_valid),
    .data(bus.adc_data[way*ADC_BITS +: ADC_BITS]),
    .skip(CNT_BITS'(SETTLE_SAMPLES)),
    .avg_n(CNT_BITS'(1 << AVG_LOG2)),
    .acc(acc),
    .skip_done(skip_done),
    .acc_done(acc_done)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.start ? SETTLE : IDLE;
      SETTLE: state_n = skip_done ? ACCUM : SETTLE;
      ACCUM: state_n = acc_done ? DECIDE : ACCUM;
      DECIDE: state_n = bit_idx == '0 ? NEXT_WAY : SETTLE;
      NEXT_WAY: state_n = last_way ? DONE : SETTLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      way <= '0;
      bit_idx <= '0;
      for (int i = 0; i < ADC_WAYS; i++) trim[i] <= TRIM_RESET;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (bus.start) begin
            way <= '0;
            bit_idx <= BIT_BITS'(TRIM_BITS - 1);
            trim[0] <= TRIM_RESET;
          end else if (bus.cfg_wen) begin
            trim[bus.cfg_way] <= bus.cfg_trim;
          end
        end
        DECIDE: begin
          if (acc > ACC_THRESH) trim[way][bit_idx] <= 1'b0;
          if (bit_idx != '0) begin
            trim[way][bit_idx - 1'b1] <= 1'b1;
            bit_idx <= bit_idx - 1'b1;
          end
        end
        NEXT_WAY: begin
          if (!last_way) begin
            way <= way + 1'b1;
            bit_idx <= BIT_BITS'(TRIM_BITS - 1);
            trim[way + 1'b1] <= TRIM_RESET;
          end
        end
        default: ;
      endcase
    end
  end
  assign bus.busy = state != IDLE && state != DONE;
  assign bus.done = state == DONE;
  for (genvar i = 0; i < ADC_WAYS; i++) begin : g_trim
    assign bus.osp[i*TRIM_BITS +: TRIM_BITS] = trim[i];
    assign bus.osm[i*TRIM_BITS +: TRIM_BITS] = ~trim[i];
  end
endmodule

// File: tb/tb_adc_offset_cal.sv
// tb_adc_offset_cal: ideal offset-ADC plant with a scoreboard of expected trims and busy lengths
module tb_adc_offset_cal;
  import adc_cal_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  adc_offset_cal_if bus();
  adc_offset_cal dut(.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int n_chk = 0;
  int n_pass = 0;
  int off[ADC_WAYS] = '{20, -13, 0, 127, -128, 5, -1, 64};
  int gold[ADC_WAYS] = '{108, 141, 128, 1, 255, 123, 129, 64};
  int exp_q[$];
  int busy_q[$];
  bit div3 = 1'b0;
  int vph = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic logic [ADC_BITS-1:0] code(input int o, input logic [TRIM_BITS-1:0] t);
    int c;
    c = 128 + o + int'(t);
    c = c < 0 ? 0 : (c > 511 ? 511 : c);
    return ADC_BITS'(c);
  endfunction
  function automatic int byte_of(input logic [ADC_WAYS*TRIM_BITS-1:0] v, input int w);
    return int'(v[w*TRIM_BITS +: TRIM_BITS]);
  endfunction
  always_comb begin
    bus.adc_data = '0;
    for (int w = 0; w < ADC_WAYS; w++)
      bus.adc_data[w*ADC_BITS +: ADC_BITS] = code(off[w], bus.osp[w*TRIM_BITS +: TRIM_BITS]);
  end
  always @(negedge clock) begin
    vph = (vph + 1) % 3;
    bus.adc_valid = !div3 || vph == 0;
  end
  task automatic run_cal(input bit slow, input bit poke, input bit wen_at_start);
    int n, busy_cnt, prev, e;
    for (int w = 0; w < ADC_WAYS; w++) exp_q.push_back(gold[w]);
    busy_q.push_back(slow ? 4608 : 1608);
    div3 = slow;
    prev = byte_of(bus.osp, 3);
    bus.start = 1'b1;
    if (wen_at_start) begin
      bus.cfg_wen = 1'b1;
      bus.cfg_way = 3'd3;
      bus.cfg_trim = 8'h55;
    end
    @(negedge clock);
    bus.start = 1'b0;
    bus.cfg_wen = 1'b0;
    if (wen_at_start) chk("wen_with_start", byte_of(bus.osp, 3), prev);
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < 20000) begin
      busy_cnt += int'(bus.busy);
      if (poke && n == 100) begin
        prev = byte_of(bus.osp, 5);
        bus.cfg_wen = 1'b1;
        bus.cfg_way = 3'd5;
        bus.cfg_trim = 8'h11;
        bus.start = 1'b1;
      end
      if (poke && n == 101) begin
        bus.cfg_wen = 1'b0;
        bus.start = 1'b0;
        chk("wen_while_busy", byte_of(bus.osp, 5), prev);
      end
      @(negedge clock);
      n++;
    end
    chk("done_seen", int'(bus.done), 1);
    e = busy_q.pop_front();
    if (slow) chk("busy_len_div3", int'(busy_cnt >= e && busy_cnt <= e + 2), 1);
    else chk("busy_len", busy_cnt, e);
    for (int w = 0; w < ADC_WAYS; w++) begin
      e = exp_q.pop_front();
      chk($sformatf("osp_way%0d", w), byte_of(bus.osp, w), e);
      chk($sformatf("osm_way%0d", w), byte_of(bus.osm, w), 255 - e);
    end
    @(negedge clock);
    chk("done_pulse_width", int'(bus.done), 0);
    chk("busy_after_done", int'(bus.busy), 0);
    div3 = 1'b0;
  endtask
  initial begin
    int seen;
    bus.start = 1'b0;
    bus.cfg_wen = 1'b0;
    bus.cfg_way = '0;
    bus.cfg_trim = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int w = 0; w < ADC_WAYS; w++) begin
      chk($sformatf("rst_osp%0d", w), byte_of(bus.osp, w), 'h80);
      chk($sformatf("rst_osm%0d", w), byte_of(bus.osm, w), 'h7F);
    end
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    bus.cfg_wen = 1'b1;
    bus.cfg_way = 3'd5;
    bus.cfg_trim = 8'h3C;
    @(negedge clock);
    bus.cfg_wen = 1'b0;
    chk("cfg_osp5", byte_of(bus.osp, 5), 'h3C);
    chk("cfg_osm5", byte_of(bus.osm, 5), 'hC3);
    run_cal(1'b0, 1'b1, 1'b0);
    run_cal(1'b1, 1'b0, 1'b0);
    run_cal(1'b0, 1'b0, 1'b1);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (699) @(negedge clock);
    chk("busy_before_abort", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    for (int w = 0; w < ADC_WAYS; w++) chk($sformatf("abort_osp%0d", w), byte_of(bus.osp, w), 'h80);
    seen = 0;
    repeat (300) begin
      @(negedge clock);
      if (bus.done || bus.busy) seen = 1;
    end
    chk("abort_quiet", seen, 0);
    run_cal(1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
